slice_subtractor: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/sub_slice.sv | 19 +
 rtl/slice_subtractor.sv | 124 ++++++++++++
 tb/tb_slice_subtractor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared state encoding and slice-count helpers for slice_subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // idx needs at least one bit even for a single-slice build
  function automatic int calc_idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtract: a - b - bin computed as a + ~b + ~bin.
module sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  logic [SLICE:0] sum;

  // carry-out of the inverted-operand add is the complement of the borrow
  assign sum  = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~bin};
  assign diff = sum[SLICE-1:0];
  assign bout = ~sum[SLICE];

endmodule

// File: rtl/slice_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, SLICE bits per cycle through one registered borrow.
// Optional signed-overflow flag port enabled by defining SUB_OVF_FLAG_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one slice per cycle, LSB slice first
// DONE  | result held with out_valid until out_ready
module slice_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int IDX_W  = calc_idx_w(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("slice_subtractor: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic [SLICE-1:0] sl_diff;
  logic             sl_bout;
  logic [WIDTH-1:0] diff_next;

  sub_slice #(.SLICE(SLICE)) u_sub_slice (
    .a    (a_q[idx*SLICE +: SLICE]),
    .b    (b_q[idx*SLICE +: SLICE]),
    .bin  (borrow),
    .diff (sl_diff),
    .bout (sl_bout)
  );

  // full result including the slice being written this cycle, so flags see the final value
  always_comb begin
    diff_next = diff;
    diff_next[idx*SLICE +: SLICE] = sl_diff;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      idx       <= '0;
      borrow    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef SUB_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            borrow   <= in_bin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff   <= diff_next;
          borrow <= sl_bout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            bout      <= sl_bout;
            zero      <= (diff_next == '0);
`ifdef SUB_OVF_FLAG_EN
            ovf       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_next[WIDTH-1] != a_q[WIDTH-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_subtractor.sv
// Self-checking bench for slice_subtractor: vector table plus scoreboard queue, reset and stall corners.
module tb_slice_subtractor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
  logic        zero;
`ifdef SUB_OVF_FLAG_EN
  logic        ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    exp_t        exp;
    int          hold;
  } vec_t;

  exp_t sb_q[$];

  slice_subtractor #(.WIDTH(16), .SLICE(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
`ifdef SUB_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] full;
    exp_t e;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    e.diff = full[15:0];
    e.bout = full[16];
    e.zero = (full[15:0] == 16'd0);
    e.ovf  = (a[15] != b[15]) && (full[15] != a[15]);
    return e;
  endfunction

  task automatic check_out(input exp_t got);
    exp_t e;
    chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("diff", 32'(got.diff), 32'(e.diff));
      chk("bout", 32'(got.bout), 32'(e.bout));
      chk("zero", 32'(got.zero), 32'(e.zero));
`ifdef SUB_OVF_FLAG_EN
      chk("ovf", 32'(got.ovf), 32'(e.ovf));
`endif
    end
  endtask

  // drives one operation; garbage in_valid pulses during RUN/DONE must be ignored
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input exp_t e, input int hold);
    int   lat;
    exp_t got;
    @(negedge clock);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_bin = bin; in_valid = 1'b1;
    @(posedge clock);
    sb_q.push_back(e);
    @(negedge clock);
    chk("in_ready_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = lat[0];
      in_a = 16'($urandom); in_b = 16'($urandom); in_bin = 1'($urandom);
      @(negedge clock);
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    got.diff = diff; got.bout = bout; got.zero = zero;
`ifdef SUB_OVF_FLAG_EN
    got.ovf = ovf;
`else
    got.ovf = 1'b0;
`endif
    check_out(got);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = 16'($urandom); in_b = 16'($urandom);
      @(negedge clock);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_diff", 32'(diff), 32'(got.diff));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}, 0});
    vecs.push_back('{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0}, 0});
    vecs.push_back('{16'h5A5A, 16'h5A59, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b0}, 0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}, 0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b0, 1'b1}, 0});
    vecs.push_back('{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b1}, 0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}, 0});
    vecs.push_back('{16'h00F0, 16'h0010, 1'b0, '{16'h00E0, 1'b0, 1'b0, 1'b0}, 5});

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, vecs[i].hold);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      do_op(ra, rb, rbin, model(ra, rb, rbin), i % 3);
    end

    // reset during the second RUN cycle discards the partial result
    @(negedge clock);
    in_a = 16'h1234; in_b = 16'h0001; in_bin = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd0);
    do_op(16'h4321, 16'h0321, 1'b1, '{16'h3FFF, 1'b0, 1'b0, 1'b0}, 1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
